// File: rtl/mux_sel_sequencer.sv
// Select sequencer for a downstream 4:1 mux: steps the 2-bit select either on a
// prescaler tick (auto) or on a debounced push-button press (manual).
module mux_sel_sequencer #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       hold,
  input  logic       step_btn,
  output logic [1:0] s,
  output logic       s_chg,
  output logic       tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEB_CYCLES);

  logic          btn_meta;
  logic          btn_sync;
  logic          btn_stable;
  logic          btn_stable_q;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pre_cnt;
  logic          step_evt;
  logic          adv;

  // Two-flop synchroniser for the raw asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
    end
  end

  // Debouncer: accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable <= 1'b0;
      deb_cnt    <= '0;
    end else if (btn_sync == btn_stable) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      btn_stable <= btn_sync;
      deb_cnt    <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Delayed copy of the stable level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable_q <= 1'b0;
    end else begin
      btn_stable_q <= btn_stable;
    end
  end

  // Press event and advance request; hold blocks both sources
  always_comb begin
    step_evt = btn_stable & ~btn_stable_q;
    adv      = ~hold & (mode ? tick : step_evt);
  end

  // Prescaler: restarts from zero whenever auto mode is not actively running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (!mode || hold) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // Select counter, modulo-4, with a change pulse in the first cycle of a new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= 2'b00;
      s_chg <= 1'b0;
    end else if (adv) begin
      s     <= s + 2'd1;
      s_chg <= 1'b1;
    end else begin
      s_chg <= 1'b0;
    end
  end

endmodule
